sd_spi_port: RTL
================

SD_SPI_PORT -- requirements
Module: sd_spi_port

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0300: I/O base; data register at BASE_ADDR, control/status register at BASE_ADDR+1.
REQ-002 Parameter FAST_DIV, default 4: SD_CK half-period in clk cycles, fast mode; legal range 1..255.
REQ-003 Parameter SLOW_DIV, default 64: SD_CK half-period in clk cycles, slow (card-init) mode; legal range 1..255.
REQ-004 clk  in  1  single clock, same domain as the CPU bus strobes.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 IOM  in  1  high = I/O cycle.
REQ-007 ADDR  in  16  CPU port address.
REQ-008 RD_n  in  1  active-low read strobe.
REQ-009 WR_n  in  1  active-low write strobe.
REQ-010 din  in  8  CPU write data.
REQ-011 dout  out  8  register read data; meaningful when oe=1.
REQ-012 oe  out  1  high when IOM=1, RD_n=0 and ADDR selects either register; combinational.
REQ-013 SD_n_CS  out  1  card chip select, active low.
REQ-014 SD_CK  out  1  SPI clock, mode 0, idle low.
REQ-015 SD_DI  out  1  SPI MOSI, MSB first.
REQ-016 SD_DO  in  1  SPI MISO; synchronised with 2 flops before use.

Function
REQ-017 Write strobe SHALL be edge-qualified: an access fires once, on the first clk where IOM=1, WR_n=0 and WR_n was 1 on the previous clk; a held WR_n SHALL NOT re-fire.
REQ-018 Data write (BASE_ADDR) while IDLE SHALL load din into tx_shift, clear the bit counter and enter LOW; data write while busy SHALL be ignored, with no change to tx_shift or rx_data.
REQ-019 Control write (BASE_ADDR+1) SHALL set SD_n_CS <= ~din[0] and slow <= din[1] at any time, including mid-transfer; slow takes effect at the next half-period reload.
REQ-020 Data read SHALL return rx_data (last completed received byte); status read SHALL return {busy, 5'b0, slow, ~SD_n_CS}.
REQ-021 FSM states IDLE, LOW, HIGH; divider reloads with (slow ? SLOW_DIV : FAST_DIV)-1 on every state entry.
REQ-022 LOW: SD_CK=0, SD_DI=tx_shift[7]; on divider expiry -> HIGH, sampling the synchronised SD_DO into rx_shift[0] after shifting rx_shift left.
REQ-023 HIGH: SD_CK=1; on divider expiry, shift tx_shift left (fill 1) and increment bit counter; if 8 bits are done -> IDLE and copy rx_shift to rx_data, else -> LOW.
REQ-024 busy=1 in LOW and HIGH; a transfer SHALL take exactly 16*DIV clk cycles from the firing write to busy=0.
REQ-025 IDLE: SD_CK=0, SD_DI=1.
REQ-026 A read in the same cycle as transfer completion SHALL return the old rx_data; the new value is visible the following cycle.
REQ-027 Bit counter is 3 bits plus done flag; no wrap-around is permitted to start a ninth bit.

Reset
REQ-028 reset_n=0 at a clk edge SHALL force: state IDLE, SD_n_CS=1, SD_CK=0, SD_DI=1, slow=1, rx_data=8'hFF, tx_shift=8'hFF, busy=0, divider 0, edge-detect history WR_n=1.
REQ-029 Reset mid-transfer SHALL abort it immediately with no rx_data update; the first post-reset write fires normally.

Structure
REQ-030 FSM state encoding and register offsets (DATA=0, CTRL=1) and status bit positions SHALL live in a shared package.
REQ-031 One sub-module, sd_spi_clkdiv (down-counter with load and expiry pulse), is natural; all else SHALL stay in sd_spi_port.

Verification
REQ-032 Reset: hold reset_n=0 2 cycles -> SD_n_CS=1, SD_CK=0, SD_DI=1, status read = 8'h02, data read = 8'hFF.
REQ-033 CTRL write 8'h01, then DATA write 8'hA5 with SD_DO looping back SD_DI (through the synchroniser) in fast mode -> SD_DI shows 1,0,1,0,0,1,0,1 on 8 rising SD_CK edges, busy for 64 cycles, then data read = 8'hA5, status = 8'h01.
REQ-034 Slow mode (CTRL 8'h03), DATA write 8'h00, SD_DO tied 1 -> SD_CK half-period is 64 cycles, busy 1024 cycles, data read = 8'hFF.
REQ-035 WR_n held low for 10 cycles on DATA -> exactly one transfer; second DATA write of 8'h3C issued mid-transfer -> ignored; tx bits match the first byte only.
REQ-036 reset_n pulsed low at bit 4 of a transfer -> outputs return to reset values next cycle, rx_data=8'hFF; a subsequent write of 8'h81 completes normally.
REQ-037 oe: read at BASE_ADDR+2 or with IOM=0 -> oe=0; read at BASE_ADDR or BASE_ADDR+1 with IOM=1 -> oe=1.

Source files
------------

// File: rtl/sd_spi_port_pkg.sv
// Shared definitions for the SD-card SPI port: FSM encoding, register offsets,
// status bit positions and the divider reload helper.
package sd_spi_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } spi_state_e;

    localparam logic [15:0] REG_DATA = 16'd0;
    localparam logic [15:0] REG_CTRL = 16'd1;

    localparam int STAT_BUSY = 7;
    localparam int STAT_SLOW = 1;
    localparam int STAT_CS   = 0;

    // Half-period counter runs from DIV-1 down to 0, so a phase lasts DIV clocks.
    function automatic logic [7:0] div_reload(input logic slow, input int slow_div,
                                              input int fast_div);
        return slow ? 8'(slow_div - 1) : 8'(fast_div - 1);
    endfunction

endpackage

// File: rtl/sd_spi_clkdiv.sv
// SD_CK half-period timer: loadable down-counter that holds at zero and flags
// expiry while the count is zero.
module sd_spi_clkdiv (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       expire
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign expire = (count == 8'd0);

endmodule

// File: rtl/sd_spi_port.sv
// CPU I/O-mapped SPI master for an SD card: data and control/status registers,
// mode-0 byte shifter with selectable slow (card init) and fast SD_CK rates.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no transfer; SD_CK low, SD_DI high, accepts data writes
// ST_LOW  | SD_CK low phase; SD_DI presents tx_shift[7]; sample MISO at end
// ST_HIGH | SD_CK high phase; shift out next bit at end, finish after bit 8
module sd_spi_port
    import sd_spi_port_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0300,
    parameter int          FAST_DIV  = 4,
    parameter int          SLOW_DIV  = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        IOM,
    input  logic [15:0] ADDR,
    input  logic        RD_n,
    input  logic        WR_n,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        oe,
    output logic        SD_n_CS,
    output logic        SD_CK,
    output logic        SD_DI,
    input  logic        SD_DO
);

    spi_state_e  state_q, state_d;
    logic [15:0] offset;
    logic        sel_data, sel_ctrl;
    logic        wr_prev, wr_fire, wr_data, wr_ctrl;
    logic [7:0]  tx_shift, rx_shift, rx_data;
    logic [3:0]  bit_cnt, bit_nxt;
    logic        slow;
    logic        do_meta, do_sync;
    logic        div_load, div_expire;
    logic        start, sample, shift_out, finish;
    logic        busy;
    logic [7:0]  status;

    assign offset   = ADDR - BASE_ADDR;
    assign sel_data = (offset == REG_DATA);
    assign sel_ctrl = (offset == REG_CTRL);

    // A held WR_n must not re-fire, so only the falling edge counts.
    assign wr_fire = IOM && !WR_n && wr_prev;
    assign wr_data = wr_fire && sel_data;
    assign wr_ctrl = wr_fire && sel_ctrl;

    assign oe = IOM && !RD_n && (sel_data || sel_ctrl);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        sample    = 1'b0;
        shift_out = 1'b0;
        finish    = 1'b0;
        // bit_cnt[3] is the done flag; it sets instead of letting [2:0] wrap.
        bit_nxt   = bit_cnt + 4'd1;
        case (state_q)
            ST_IDLE: begin
                if (wr_data) begin
                    start   = 1'b1;
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (div_expire) begin
                    sample  = 1'b1;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (div_expire) begin
                    shift_out = 1'b1;
                    if (bit_nxt[3]) begin
                        finish  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOW;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign SD_CK    = (state_q == ST_HIGH);
    assign SD_DI    = (state_q == ST_IDLE) ? 1'b1 : tx_shift[7];
    assign div_load = (state_d != state_q);

    sd_spi_clkdiv u_clkdiv (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (div_load),
        .load_val (div_reload(slow, SLOW_DIV, FAST_DIV)),
        .expire   (div_expire)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_prev  <= 1'b1;
            do_meta  <= 1'b1;
            do_sync  <= 1'b1;
            SD_n_CS  <= 1'b1;
            slow     <= 1'b1;
            tx_shift <= 8'hFF;
            rx_shift <= 8'hFF;
            rx_data  <= 8'hFF;
            bit_cnt  <= 4'd0;
        end else begin
            wr_prev <= WR_n;
            do_meta <= SD_DO;
            do_sync <= do_meta;
            if (wr_ctrl) begin
                SD_n_CS <= ~din[0];
                slow    <= din[1];
            end
            if (start) begin
                tx_shift <= din;
                bit_cnt  <= 4'd0;
            end else if (shift_out) begin
                tx_shift <= {tx_shift[6:0], 1'b1};
                bit_cnt  <= bit_nxt;
            end
            if (sample) begin
                rx_shift <= {rx_shift[6:0], do_sync};
            end
            if (finish) begin
                rx_data <= rx_shift;
            end
        end
    end

    always_comb begin
        status            = 8'h00;
        status[STAT_BUSY] = busy;
        status[STAT_SLOW] = slow;
        status[STAT_CS]   = ~SD_n_CS;
    end

    assign dout = sel_ctrl ? status : rx_data;

endmodule
